pipeline_stage_ctrl: RTL and testbench

- Consumer of the hazard unit's stall and flush requests.
- Owns the per-stage valid bits and pipeline-register enables for the 5-stage core (IF/ID/EX/MEM/WB).
- Tracks each in-flight destination register, zeroed for bubbles, and feeds these back to the hazard unit as its rd inputs.
- Gates the WB register-file write and keeps a retired-instruction counter and a stall-cycle counter.

---
 rtl/pipeline_stage_ctrl.sv | 237 +++++++++++++++++++++++
 tb/tb_pipeline_stage_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_stage_ctrl.sv
// ============================================================================
// pipeline_stage_ctrl
// ----------------------------------------------------------------------------
// Pipeline sequencing for the 5-stage core (IF/ID/EX/MEM/WB). Takes the
// hazard unit's stall (stop_ID), flush (took_branch) and freeze (mem_busy)
// requests and turns them into per-stage valid bits, pipeline register
// enables, tracked destination registers (fed back to the hazard unit), the
// WB register-file write strobe and two free-running performance counters.
//
// Ports
//   clk           core clock, rising edge
//   reset         asynchronous, active-high; clears all state at once
//   fetch_valid   IF presents a valid instruction to ID this cycle
//   rd_IF         destination register of the instruction entering ID
//   wen_IF        the instruction entering ID writes rd_IF
//   stop_ID       load-use stall request
//   took_branch   branch/jump in EX taken; squash the two younger slots
//   mem_busy      data memory not ready; freeze the whole pipeline
//   en_IF         PC / IF-ID register enable
//   en_ID         ID-EX register enable
//   en_EX         EX-MEM register enable
//   en_MEM        MEM-WB register enable
//   valid_*       stage holds a real instruction
//   rd_*          stage destination, 0 when invalid or not writing
//   reg_write_WB  register-file write strobe
//   retired       instructions that left WB (wraps)
//   stall_cycles  cycles with a stall or freeze request (wraps)
// ============================================================================
module pipeline_stage_ctrl #(
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             fetch_valid,
    input  logic [4:0]       rd_IF,
    input  logic             wen_IF,
    input  logic             stop_ID,
    input  logic             took_branch,
    input  logic             mem_busy,
    output logic             en_IF,
    output logic             en_ID,
    output logic             en_EX,
    output logic             en_MEM,
    output logic             valid_ID,
    output logic             valid_EX,
    output logic             valid_MEM,
    output logic             valid_WB,
    output logic [4:0]       rd_ID,
    output logic [4:0]       rd_EX,
    output logic [4:0]       rd_MEM,
    output logic [4:0]       rd_WB,
    output logic             reg_write_WB,
    output logic [CNT_W-1:0] retired,
    output logic [CNT_W-1:0] stall_cycles
);

    // What the pipeline does on the coming edge, already prioritised.
    localparam logic [1:0] STEP_NORMAL = 2'd0;
    localparam logic [1:0] STEP_FLUSH  = 2'd1;
    localparam logic [1:0] STEP_STALL  = 2'd2;
    localparam logic [1:0] STEP_FREEZE = 2'd3;

    // A destination is only visible when the slot is live, writes, and is
    // not x0 -- the hazard unit never has to special-case bubbles or x0.
    function automatic logic [4:0] rd_visible(input logic v, input logic w,
                                              input logic [4:0] r);
        return (v && w && (r != 5'd0)) ? r : 5'd0;
    endfunction

    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
        return c + CNT_W'(1);
    endfunction

    logic [1:0] step;

    // Registered stage state
    logic       v_id, v_ex, v_mem, v_wb;
    logic       w_id, w_ex, w_mem, w_wb;
    logic [4:0] r_id, r_ex, r_mem, r_wb;

    // Next-state values
    logic       v_id_n, v_ex_n, v_mem_n, v_wb_n;
    logic       w_id_n, w_ex_n, w_mem_n, w_wb_n;
    logic [4:0] r_id_n, r_ex_n, r_mem_n, r_wb_n;

    logic retire_fire;
    logic stall_fire;

    always_comb begin
        if (mem_busy) begin
            step = STEP_FREEZE;
        end else if (took_branch) begin
            step = STEP_FLUSH;
        end else if (stop_ID) begin
            step = STEP_STALL;
        end else begin
            step = STEP_NORMAL;
        end
    end

    // Enables are forced low while reset is held so nothing downstream
    // captures during the reset window.
    always_comb begin
        en_EX  = !reset && (step != STEP_FREEZE);
        en_MEM = !reset && (step != STEP_FREEZE);
        en_IF  = !reset && ((step == STEP_NORMAL) || (step == STEP_FLUSH));
        en_ID  = !reset && ((step == STEP_NORMAL) || (step == STEP_FLUSH));
    end

    always_comb begin
        // Default: every stage holds (freeze behaviour).
        v_id_n  = v_id;
        w_id_n  = w_id;
        r_id_n  = r_id;
        v_ex_n  = v_ex;
        w_ex_n  = w_ex;
        r_ex_n  = r_ex;
        v_mem_n = v_mem;
        w_mem_n = w_mem;
        r_mem_n = r_mem;
        v_wb_n  = v_wb;
        w_wb_n  = w_wb;
        r_wb_n  = r_wb;

        case (step)
            STEP_NORMAL: begin
                v_id_n  = fetch_valid;
                w_id_n  = fetch_valid && wen_IF;
                r_id_n  = rd_IF;
                v_ex_n  = v_id;
                w_ex_n  = w_id;
                r_ex_n  = r_id;
                v_mem_n = v_ex;
                w_mem_n = w_ex;
                r_mem_n = r_ex;
                v_wb_n  = v_mem;
                w_wb_n  = w_mem;
                r_wb_n  = r_mem;
            end
            STEP_FLUSH: begin
                // The fetched instruction and the one in ID are wrong-path;
                // the branch itself (in EX) carries on into MEM.
                v_id_n  = 1'b0;
                w_id_n  = 1'b0;
                r_id_n  = 5'd0;
                v_ex_n  = 1'b0;
                w_ex_n  = 1'b0;
                r_ex_n  = 5'd0;
                v_mem_n = v_ex;
                w_mem_n = w_ex;
                r_mem_n = r_ex;
                v_wb_n  = v_mem;
                w_wb_n  = w_mem;
                r_wb_n  = r_mem;
            end
            STEP_STALL: begin
                // ID holds its instruction; a bubble goes into EX while the
                // older instructions drain forward.
                v_ex_n  = 1'b0;
                w_ex_n  = 1'b0;
                r_ex_n  = 5'd0;
                v_mem_n = v_ex;
                w_mem_n = w_ex;
                r_mem_n = r_ex;
                v_wb_n  = v_mem;
                w_wb_n  = w_mem;
                r_wb_n  = r_mem;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v_id  <= 1'b0;
            v_ex  <= 1'b0;
            v_mem <= 1'b0;
            v_wb  <= 1'b0;
            w_id  <= 1'b0;
            w_ex  <= 1'b0;
            w_mem <= 1'b0;
            w_wb  <= 1'b0;
            r_id  <= 5'd0;
            r_ex  <= 5'd0;
            r_mem <= 5'd0;
            r_wb  <= 5'd0;
        end else begin
            v_id  <= v_id_n;
            v_ex  <= v_ex_n;
            v_mem <= v_mem_n;
            v_wb  <= v_wb_n;
            w_id  <= w_id_n;
            w_ex  <= w_ex_n;
            w_mem <= w_mem_n;
            w_wb  <= w_wb_n;
            r_id  <= r_id_n;
            r_ex  <= r_ex_n;
            r_mem <= r_mem_n;
            r_wb  <= r_wb_n;
        end
    end

    // An instruction held in WB by mem_busy retires (and writes) only on the
    // cycle the freeze lifts, so each retirement is counted exactly once.
    assign retire_fire = v_wb && !mem_busy;
    assign stall_fire  = (stop_ID && !took_branch) || mem_busy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retired      <= '0;
            stall_cycles <= '0;
        end else begin
            if (retire_fire) begin
                retired <= cnt_inc(retired);
            end
            if (stall_fire) begin
                stall_cycles <= cnt_inc(stall_cycles);
            end
        end
    end

    // Outputs depend only on registered state (plus mem_busy for the write
    // strobe), so the hazard unit's rd loop has no combinational path.
    assign valid_ID  = v_id;
    assign valid_EX  = v_ex;
    assign valid_MEM = v_mem;
    assign valid_WB  = v_wb;

    assign rd_ID  = rd_visible(v_id, w_id, r_id);
    assign rd_EX  = rd_visible(v_ex, w_ex, r_ex);
    assign rd_MEM = rd_visible(v_mem, w_mem, r_mem);
    assign rd_WB  = rd_visible(v_wb, w_wb, r_wb);

    assign reg_write_WB = (rd_WB != 5'd0) && !mem_busy;

endmodule

// File: tb/tb_pipeline_stage_ctrl.sv
// ============================================================================
// tb_pipeline_stage_ctrl
// Directed bench for pipeline_stage_ctrl. Every instruction that should reach
// the register file is queued when it is accepted into ID; each write strobe
// seen at WB pops the queue and must name the same register.
// ============================================================================
module tb_pipeline_stage_ctrl;

    localparam int CNT_W = 64;

    logic             clk;
    logic             reset;
    logic             fetch_valid;
    logic [4:0]       rd_IF;
    logic             wen_IF;
    logic             stop_ID;
    logic             took_branch;
    logic             mem_busy;
    logic             en_IF, en_ID, en_EX, en_MEM;
    logic             valid_ID, valid_EX, valid_MEM, valid_WB;
    logic [4:0]       rd_ID, rd_EX, rd_MEM, rd_WB;
    logic             reg_write_WB;
    logic [CNT_W-1:0] retired;
    logic [CNT_W-1:0] stall_cycles;

    int checks;
    int errors;
    int nwrites;
    int exp_q[$];

    logic [CNT_W-1:0] r0;
    logic [CNT_W-1:0] s0;

    pipeline_stage_ctrl #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .fetch_valid  (fetch_valid),
        .rd_IF        (rd_IF),
        .wen_IF       (wen_IF),
        .stop_ID      (stop_ID),
        .took_branch  (took_branch),
        .mem_busy     (mem_busy),
        .en_IF        (en_IF),
        .en_ID        (en_ID),
        .en_EX        (en_EX),
        .en_MEM       (en_MEM),
        .valid_ID     (valid_ID),
        .valid_EX     (valid_EX),
        .valid_MEM    (valid_MEM),
        .valid_WB     (valid_WB),
        .rd_ID        (rd_ID),
        .rd_EX        (rd_EX),
        .rd_MEM       (rd_MEM),
        .rd_WB        (rd_WB),
        .reg_write_WB (reg_write_WB),
        .retired      (retired),
        .stall_cycles (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs; queue the expected write if ID accepts it.
    task automatic drive(input logic fv, input logic [4:0] rd, input logic wen,
                         input logic stp, input logic br, input logic busy);
        fetch_valid = fv;
        rd_IF       = rd;
        wen_IF      = wen;
        stop_ID     = stp;
        took_branch = br;
        mem_busy    = busy;
        if (fv && wen && (rd != 5'd0) && !stp && !br && !busy) begin
            exp_q.push_back(int'(rd));
        end
    endtask

    // Score the write strobe mid-cycle, then advance past the next edge.
    task automatic cycle();
        @(negedge clk);
        if (reg_write_WB === 1'b1) begin
            nwrites++;
            if (exp_q.size() == 0) begin
                chk("unexpected_write", 64'(rd_WB), 64'd0);
            end else begin
                chk("wb_write_rd", 64'(rd_WB), 64'(exp_q.pop_front()));
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        nwrites = 0;
        reset   = 1'b1;
        drive(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        chk("rst_valid_WB", 64'(valid_WB), 64'd0);
        chk("rst_rd_ID", 64'(rd_ID), 64'd0);
        chk("rst_en_IF", 64'(en_IF), 64'd0);
        chk("rst_en_MEM", 64'(en_MEM), 64'd0);
        chk("rst_retired", retired, 64'd0);
        chk("rst_stall", stall_cycles, 64'd0);
        chk("rst_reg_write", 64'(reg_write_WB), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // ---- back-to-back instructions rd 1..5 ----
        for (int i = 1; i <= 5; i++) begin
            drive(1'b1, 5'(i), 1'b1, 1'b0, 1'b0, 1'b0);
            if (i == 1) begin
                #1;
                chk("t1_en_IF", 64'(en_IF), 64'd1);
            end
            cycle();
            if (i == 1) chk("t1_rd_ID_first", 64'(rd_ID), 64'd1);
            if (i == 4) chk("t1_rd_WB_first", 64'(rd_WB), 64'd1);
        end
        drive(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (5) cycle();
        chk("t1_retired", retired, 64'd5);
        chk("t1_writes", 64'(nwrites), 64'd5);

        // ---- one-cycle load-use stall ----
        drive(1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle();
        chk("t2_rd_ID", 64'(rd_ID), 64'd7);
        drive(1'b1, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0);
        #1;
        chk("t2_en_IF_stall", 64'(en_IF), 64'd0);
        chk("t2_en_ID_stall", 64'(en_ID), 64'd0);
        chk("t2_en_EX_stall", 64'(en_EX), 64'd1);
        chk("t2_en_MEM_stall", 64'(en_MEM), 64'd1);
        cycle();
        chk("t2_rd_ID_held", 64'(rd_ID), 64'd7);
        chk("t2_rd_EX_bubble", 64'(rd_EX), 64'd0);
        chk("t2_valid_EX_bubble", 64'(valid_EX), 64'd0);
        drive(1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        chk("t2_en_IF_after", 64'(en_IF), 64'd1);
        chk("t2_en_ID_after", 64'(en_ID), 64'd1);
        cycle();
        chk("t2_rd_EX", 64'(rd_EX), 64'd7);
        chk("t2_rd_ID_next", 64'(rd_ID), 64'd8);
        chk("t2_stall_cycles", stall_cycles, 64'd1);
        drive(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (5) cycle();

        // ---- taken branch overriding a stall ----
        drive(1'b1, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle();
        drive(1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle();
        s0 = stall_cycles;
        drive(1'b1, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0);
        exp_q.pop_back();   // rd 3, sitting in ID, is wrong-path
        #1;
        chk("t3_en_IF_branch", 64'(en_IF), 64'd1);
        cycle();
        chk("t3_valid_ID", 64'(valid_ID), 64'd0);
        chk("t3_valid_EX", 64'(valid_EX), 64'd0);
        chk("t3_rd_MEM_branch", 64'(rd_MEM), 64'd10);
        chk("t3_stall_unchanged", stall_cycles, s0);
        drive(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (4) cycle();

        // ---- three-cycle memory freeze with x9 in WB, x12 in MEM ----
        drive(1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle();
        drive(1'b1, 5'd12, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle();
        drive(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle();
        cycle();
        r0 = retired;
        s0 = stall_cycles;
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
            #1;
            chk("t4_reg_write_busy", 64'(reg_write_WB), 64'd0);
            chk("t4_valid_WB_frozen", 64'(valid_WB), 64'd1);
            chk("t4_rd_WB_frozen", 64'(rd_WB), 64'd9);
            chk("t4_rd_MEM_frozen", 64'(rd_MEM), 64'd12);
            chk("t4_en_IF_busy", 64'(en_IF), 64'd0);
            chk("t4_en_MEM_busy", 64'(en_MEM), 64'd0);
            cycle();
        end
        chk("t4_retired_held", retired, r0);
        drive(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("t4_reg_write_release", 64'(reg_write_WB), 64'd1);
        cycle();
        chk("t4_retired", retired, r0 + 64'd1);
        chk("t4_stall_cycles", stall_cycles, s0 + 64'd3);
        chk("t4_rd_WB_next", 64'(rd_WB), 64'd12);
        repeat (3) cycle();

        // ---- rd = 0 with wen = 1 ----
        drive(1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle();
        chk("t5_valid_ID", 64'(valid_ID), 64'd1);
        chk("t5_rd_ID", 64'(rd_ID), 64'd0);
        drive(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle();
        chk("t5_rd_EX", 64'(rd_EX), 64'd0);
        cycle();
        chk("t5_rd_MEM", 64'(rd_MEM), 64'd0);
        cycle();
        r0 = retired;
        chk("t5_valid_WB", 64'(valid_WB), 64'd1);
        chk("t5_rd_WB", 64'(rd_WB), 64'd0);
        chk("t5_reg_write", 64'(reg_write_WB), 64'd0);
        cycle();
        chk("t5_retired", retired, r0 + 64'd1);

        // ---- asynchronous reset in the middle of a stall ----
        drive(1'b1, 5'd20, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle();
        drive(1'b1, 5'd21, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle();
        drive(1'b1, 5'd22, 1'b1, 1'b1, 1'b0, 1'b0);
        cycle();
        #2;
        reset = 1'b1;
        #1;
        chk("t6_valid_ID", 64'(valid_ID), 64'd0);
        chk("t6_valid_MEM", 64'(valid_MEM), 64'd0);
        chk("t6_rd_ID", 64'(rd_ID), 64'd0);
        chk("t6_rd_MEM", 64'(rd_MEM), 64'd0);
        chk("t6_retired", retired, 64'd0);
        chk("t6_stall", stall_cycles, 64'd0);
        chk("t6_en_EX", 64'(en_EX), 64'd0);
        exp_q.delete();
        drive(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        reset = 1'b0;
        repeat (3) cycle();
        chk("t6_post_valid_ID", 64'(valid_ID), 64'd0);
        chk("t6_post_valid_EX", 64'(valid_EX), 64'd0);
        chk("t6_post_valid_WB", 64'(valid_WB), 64'd0);
        chk("t6_post_retired", retired, 64'd0);
        chk("t6_post_stall", stall_cycles, 64'd0);
        drive(1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle();
        chk("t6_stall_restart", stall_cycles, 64'd1);
        drive(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle();

        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        chk("total_writes", 64'(nwrites), 64'd10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
